glitch_scheduler: RTL
=====================

Name: glitch_scheduler

Overview:
Sequences glitch injection for the clock glitcher. On a start command it optionally pulses the PLL reset for a relock and waits for lock. It then arms on an external trigger edge, waits a programmed delay, and drives a gated glitch enable for a programmed width. Pulses repeat with a programmed gap. It sits between the soft-CPU GPIO/config registers and the clock-mux select feeding the glitched output pin.

Parameters:
CNT_W, 16, width of delay/width/gap counters and config fields
REP_W, 8, width of repeat count and pulse counter
RELOCK_CYC, 4, cycles pll_relock is held high during the relock phase
LOCK_TIMEOUT, 4096, max cycles to wait for pll_locked before error

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle command; honoured only in IDLE
abort  in  1  return to IDLE from any state
cfg_relock  in  1  1 = do PLL relock before arming
cfg_delay  in  CNT_W  cycles from trigger edge to first glitch
cfg_width  in  CNT_W  glitch length in cycles (0 treated as 1)
cfg_gap  in  CNT_W  low cycles between pulses (0 treated as 1)
cfg_repeat  in  REP_W  extra pulses after the first (total = cfg_repeat+1)
trigger  in  1  target trigger, already synchronous to clk
pll_locked  in  1  PLL lock indicator
pll_relock  out  1  PLL reset request
glitch_en  out  1  selects glitched clock at the output mux
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on normal completion
lock_err  out  1  sticky lock-timeout flag; cleared by accepted start or reset
pulse_count  out  REP_W  pulses issued in current/last run; cleared by accepted start

Behaviour:
- Reset: state IDLE. pll_relock, glitch_en, busy, done, lock_err = 0. pulse_count = 0. Counters = 0. trigger_q = 0.
- All outputs are registered.
- cfg_* are latched on the accepted start. Later changes have no effect until the next run.
- IDLE -> RELOCK if cfg_relock=1, else -> ARMED. Requires start=1 and abort=0.
- RELOCK: pll_relock=1 for exactly RELOCK_CYC cycles, then -> WAIT_LOCK. pll_relock=0 in WAIT_LOCK.
- WAIT_LOCK:
  - pll_locked=1 -> ARMED.
  - After LOCK_TIMEOUT cycles without lock: lock_err<=1, -> IDLE, no done.
  - The first cycle of WAIT_LOCK ignores pll_locked, to reject stale lock.
- ARMED: edge = trigger & ~trigger_q. trigger_q updates every cycle in every state. An edge already present in the cycle of entry does count.
- Edge seen in cycle T:
  - glitch_en is high exactly in cycles T+1+cfg_delay .. T+cfg_delay+max(cfg_width,1).
  - States run DELAY (skipped when cfg_delay=0) then GLITCH.
- GLITCH end:
  - If pulses issued < cfg_repeat+1: -> GAP. glitch_en is low max(cfg_gap,1) cycles, then -> GLITCH.
  - Else -> DONE.
- pulse_count increments in the first cycle of each GLITCH. It saturates at 2^REP_W-1.
- DONE: done=1 for one cycle, -> IDLE. busy=0 from the following cycle.
- Trigger edges are ignored outside ARMED. There is no retrigger.
- abort has priority over every transition except reset. The next cycle is IDLE with glitch_en=0 and pll_relock=0. No done; lock_err unchanged.
- start while busy is ignored. start and abort together in IDLE means stay in IDLE.

Decomposition:
- Package glitch_pkg holds:
  - state enum: IDLE, RELOCK, WAIT_LOCK, ARMED, DELAY, GLITCH, GAP, DONE.
  - default constants for CNT_W, REP_W, RELOCK_CYC, LOCK_TIMEOUT.
- One natural sub-module is glitch_downcnt: loadable CNT_W down-counter with a zero flag. It is shared by the DELAY, GLITCH, GAP, RELOCK and timeout phases, since only one phase is active at a time.

Test Plan:
- cfg_relock=0, delay=3, width=2, repeat=0; start at cycle 0, trigger rises at cycle 10 -> glitch_en high cycles 14-15 only; done at 16; pulse_count=1.
- delay=0, width=0, gap=0, repeat=2; trigger edge at T -> glitch_en pattern 1,0,1,0,1 starting T+1; pulse_count=3; one done pulse.
- cfg_relock=1, RELOCK_CYC=4, pll_locked rises 20 cycles after relock ends -> pll_relock high exactly 4 cycles; ARMED reached; trigger then yields a normal pulse.
- cfg_relock=1, pll_locked held 0, LOCK_TIMEOUT=64 -> lock_err=1 after 64 WAIT_LOCK cycles; busy=0; no done. A new start clears lock_err.
- abort asserted mid-GLITCH with width=100 -> glitch_en=0 and state IDLE next cycle; no done; pulse_count retained.
- Trigger toggling in IDLE/DELAY, start pulses while busy, and cfg changes mid-run -> no extra pulses; timing matches the latched config.

Source files
------------

// File: rtl/glitch_pkg.sv
// Shared types and default parameters for the glitch scheduler slice.
package glitch_pkg;

    localparam int DEF_CNT_W        = 16;
    localparam int DEF_REP_W        = 8;
    localparam int DEF_RELOCK_CYC   = 4;
    localparam int DEF_LOCK_TIMEOUT = 4096;

    typedef enum logic [2:0] {
        IDLE,
        RELOCK,
        WAIT_LOCK,
        ARMED,
        DELAY,
        GLITCH,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/glitch_downcnt.sv
// Loadable down-counter with a zero flag. The scheduler reuses one instance
// for every timed phase because only one phase is ever active.
module glitch_downcnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // Load wins over counting; the counter parks at zero until reloaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/glitch_scheduler.sv
// Glitch injection sequencer: optional PLL relock, trigger arming, then a
// train of glitch pulses separated by gaps, all timed from one down-counter.
module glitch_scheduler
    import glitch_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int REP_W        = DEF_REP_W,
    parameter int RELOCK_CYC   = DEF_RELOCK_CYC,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_relock,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [REP_W-1:0] cfg_repeat,
    input  logic             trigger,
    input  logic             pll_locked,
    output logic             pll_relock,
    output logic             glitch_en,
    output logic             busy,
    output logic             done,
    output logic             lock_err,
    output logic [REP_W-1:0] pulse_count
);

    // Each phase loads (length - 1) so that the zero cycle is its last cycle.
    localparam logic [CNT_W-1:0] RELOCK_LOAD  = CNT_W'(RELOCK_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] delay_q;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] gap_q;
    logic [REP_W-1:0] rep_left;
    logic             trigger_q;
    logic             trig_edge;
    logic             accept;
    logic             timeout_hit;
    logic             wl_first;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    assign trig_edge = trigger & ~trigger_q;
    assign accept    = (state == IDLE) && start && !abort;
    // The timeout count is still at its load value only in the first WAIT_LOCK cycle.
    assign wl_first  = (cnt == TIMEOUT_LOAD);

    glitch_downcnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // Next-state decision; abort overrides whatever the phase logic chose.
    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE:      if (start) state_next = cfg_relock ? RELOCK : ARMED;
            RELOCK:    if (cnt_zero) state_next = WAIT_LOCK;
            WAIT_LOCK: begin
                if (!wl_first && pll_locked) begin
                    state_next = ARMED;
                end else if (cnt_zero) begin
                    state_next  = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            ARMED:     if (trig_edge) state_next = (delay_q == '0) ? GLITCH : DELAY;
            DELAY:     if (cnt_zero) state_next = GLITCH;
            GLITCH:    if (cnt_zero) state_next = (rep_left != '0) ? GAP : DONE;
            GAP:       if (cnt_zero) state_next = GLITCH;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        if (abort) begin
            state_next  = IDLE;
            timeout_hit = 1'b0;
        end
    end

    // Reload the shared counter with the length of whichever phase is being entered.
    always_comb begin
        cnt_load     = (state_next != state);
        cnt_load_val = '0;
        case (state_next)
            RELOCK:    cnt_load_val = RELOCK_LOAD;
            WAIT_LOCK: cnt_load_val = TIMEOUT_LOAD;
            DELAY:     cnt_load_val = delay_q - CNT_W'(1);
            GLITCH:    cnt_load_val = (width_q == '0) ? '0 : width_q - CNT_W'(1);
            GAP:       cnt_load_val = (gap_q == '0) ? '0 : gap_q - CNT_W'(1);
            default:   cnt_load_val = '0;
        endcase
    end

    // State register and trigger history, which is tracked in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            trigger_q <= 1'b0;
        end else begin
            state     <= state_next;
            trigger_q <= trigger;
        end
    end

    // Outputs are registered copies of what the next state implies.
    always_ff @(posedge clk) begin
        if (reset) begin
            pll_relock <= 1'b0;
            glitch_en  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            pll_relock <= (state_next == RELOCK);
            glitch_en  <= (state_next == GLITCH);
            busy       <= (state_next != IDLE);
            done       <= (state_next == DONE);
        end
    end

    // Run bookkeeping: config capture, remaining repeats, pulse count and lock error.
    always_ff @(posedge clk) begin
        if (reset) begin
            delay_q     <= '0;
            width_q     <= '0;
            gap_q       <= '0;
            rep_left    <= '0;
            pulse_count <= '0;
            lock_err    <= 1'b0;
        end else if (accept) begin
            delay_q     <= cfg_delay;
            width_q     <= cfg_width;
            gap_q       <= cfg_gap;
            rep_left    <= cfg_repeat;
            pulse_count <= '0;
            lock_err    <= 1'b0;
        end else begin
            if (timeout_hit) begin
                lock_err <= 1'b1;
            end
            if ((state_next == GLITCH) && (state != GLITCH) && (pulse_count != {REP_W{1'b1}})) begin
                pulse_count <= pulse_count + REP_W'(1);
            end
            if ((state == GAP) && (state_next == GLITCH)) begin
                rep_left <= rep_left - REP_W'(1);
            end
        end
    end

endmodule
